// File: rtl/apb_multi_timer_if.sv
// APB slave bus bundle for the multi-channel timer.
// Handshake: a transfer is a setup cycle (PSEL & !PENABLE) followed by an
// access cycle (PSEL & PENABLE); the access completes on the clock edge where
// PREADY is high. PREADY is always high here, so every access completes after
// exactly one access cycle. PSLVERR is only meaningful during the access cycle.
interface apb_multi_timer_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_multi_timer.sv
// NCH independent up-counting timers behind one APB slave. Each channel has a
// LOAD register (terminal value), a read-only VALUE counter and a CTRL register
// (EN, ONESHOT, IRQEN). Terminal events set a sticky, write-1-to-clear STATUS
// bit; irq[i] = STATUS[i] & IRQEN[i]. Unmapped channel addresses raise PSLVERR.
module apb_multi_timer #(
   parameter int NCH   = 4,
   parameter int WIDTH = 32
) (
   input  logic             PCLK,
   input  logic             PRESET,
   apb_multi_timer_if.slave apb,
   output logic [NCH-1:0]   irq,
   output logic             irq_any
);

   logic [3:0]       addr_ch;
   logic [1:0]       addr_off;
   logic             ch_mapped;
   logic             stat_sel;
   logic             addr_err;
   logic             wr_ok;
   logic             rd_setup;
   logic [31:0]      rd_mux;

   logic [WIDTH-1:0] load_q [NCH];
   logic [WIDTH-1:0] cnt_q  [NCH];
   logic [NCH-1:0]   en_q;
   logic [NCH-1:0]   oneshot_q;
   logic [NCH-1:0]   irqen_q;
   logic [NCH-1:0]   status_q;

   logic [NCH-1:0]   load_wr;
   logic [NCH-1:0]   ctrl_wr;
   logic [NCH-1:0]   term;
   logic [NCH-1:0]   w1c_mask;

   logic             unused_ok;

   // Address decode: channel space, the STATUS register, and the error region
   // (channel numbers past NCH, excluding the 0xF global page).
   assign addr_ch   = apb.PADDR[7:4];
   assign addr_off  = apb.PADDR[3:2];
   assign ch_mapped = (int'(addr_ch) < NCH);
   assign stat_sel  = (addr_ch == 4'hF) && (addr_off == 2'd0);
   assign addr_err  = !ch_mapped && (addr_ch != 4'hF);

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = apb.PSEL && apb.PENABLE && addr_err;

   // Erroring writes are dropped entirely.
   assign wr_ok    = apb.PSEL && apb.PENABLE && apb.PWRITE && !addr_err;
   assign rd_setup = apb.PSEL && !apb.PENABLE && !apb.PWRITE;

   assign w1c_mask = (wr_ok && stat_sel) ? apb.PWDATA[NCH-1:0] : '0;

   assign irq     = status_q & irqen_q;
   assign irq_any = |irq;

   // Low address bits and unused write-data bits are intentionally ignored.
   assign unused_ok = ^{apb.PADDR[1:0], apb.PWDATA};

   // Per-channel write strobes and terminal detection; a LOAD write suppresses
   // the terminal event in the same cycle.
   always_comb begin
      load_wr = '0;
      ctrl_wr = '0;
      term    = '0;
      for (int i = 0; i < NCH; i++) begin
         load_wr[i] = wr_ok && ch_mapped && (int'(addr_ch) == i) && (addr_off == 2'd0);
         ctrl_wr[i] = wr_ok && ch_mapped && (int'(addr_ch) == i) && (addr_off == 2'd2);
         term[i]    = !load_wr[i] && en_q[i] && (cnt_q[i] == load_q[i]);
      end
   end

   // Read data selection; reserved and unmapped locations read as zero.
   always_comb begin
      rd_mux = '0;
      if (stat_sel) begin
         rd_mux = 32'(status_q);
      end
      for (int i = 0; i < NCH; i++) begin
         if (ch_mapped && (int'(addr_ch) == i)) begin
            case (addr_off)
               2'd0:    rd_mux = 32'(load_q[i]);
               2'd1:    rd_mux = 32'(cnt_q[i]);
               2'd2:    rd_mux = {29'd0, irqen_q[i], oneshot_q[i], en_q[i]};
               default: rd_mux = '0;
            endcase
         end
      end
   end

   // Channel registers and counters; a CTRL write overrides the one-shot EN clear.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < NCH; i++) begin
            load_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         en_q      <= '0;
         oneshot_q <= '0;
         irqen_q   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load_wr[i]) begin
               load_q[i] <= apb.PWDATA[WIDTH-1:0];
            end

            if (ctrl_wr[i]) begin
               en_q[i]      <= apb.PWDATA[0];
               oneshot_q[i] <= apb.PWDATA[1];
               irqen_q[i]   <= apb.PWDATA[2];
            end else if (term[i] && oneshot_q[i]) begin
               en_q[i] <= 1'b0;
            end

            if (load_wr[i] || !en_q[i] || term[i]) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + WIDTH'(1);
            end
         end
      end
   end

   // Sticky status: hardware set beats a simultaneous write-1-to-clear.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         status_q <= '0;
      end else begin
         status_q <= (status_q & ~w1c_mask) | term;
      end
   end

   // Read data is captured at the setup edge so it is stable for the access phase.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         apb.PRDATA <= '0;
      end else if (rd_setup) begin
         apb.PRDATA <= rd_mux;
      end
   end

endmodule

// File: tb/tb_apb_multi_timer.sv
// Bench for apb_multi_timer configured with NCH=2, WIDTH=8. Timing-dependent
// expectations are derived from a free-running edge counter (cyc): after the
// write that enables a channel completes at edge t0, the counter holds
// (k mod (LOAD+1)) after edge t0+k, and a read issued at cyc=c samples the
// counter as it stood after edge c+1.
module tb_apb_multi_timer;

   logic       PCLK;
   logic       PRESET;
   logic [1:0] irq;
   logic       irq_any;

   apb_multi_timer_if apb_if ();

   apb_multi_timer #(
      .NCH   (2),
      .WIDTH (8)
   ) u_dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .apb     (apb_if.slave),
      .irq     (irq),
      .irq_any (irq_any)
   );

   // Clock and edge counter
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int unsigned cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // Scoreboard state
   logic [31:0] exp_q[$];
   logic        err_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Driver tasks: each returns 1ns after its final clock edge.
   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b1;
      apb_if.PADDR   = addr;
      apb_if.PWDATA  = data;
      @(posedge PCLK); #1;
      apb_if.PENABLE = 1'b1;
      #1;
      err = apb_if.PSLVERR;
      @(posedge PCLK); #1;
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      logic err;
      apb_write(addr, data, err);
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      apb_if.PSEL    = 1'b1;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b0;
      apb_if.PADDR   = addr;
      @(posedge PCLK); #1;
      apb_if.PENABLE = 1'b1;
      #1;
      data = apb_if.PRDATA;
      err  = apb_if.PSLVERR;
      @(posedge PCLK); #1;
      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
   endtask

   task automatic rd_expect(input string tag, input logic [7:0] addr,
                            input logic [31:0] exp, input logic exp_err);
      logic [31:0] data;
      logic        err;
      logic [31:0] e_data;
      logic        e_err;
      exp_q.push_back(exp);
      err_q.push_back(exp_err);
      apb_read(addr, data, err);
      e_data = exp_q.pop_front();
      e_err  = err_q.pop_front();
      chk(tag, data, e_data);
      chk({tag, "_slverr"}, {31'd0, err}, {31'd0, e_err});
   endtask

   // Wait until (cyc - base) mod per == phase.
   task automatic align(input int unsigned base, input int unsigned per, input int unsigned phase);
      while (((cyc - base) % per) != phase) begin
         @(posedge PCLK); #1;
      end
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit");
   end

   int unsigned t0;
   int unsigned t1;
   int unsigned t2;
   logic        werr;

   initial begin
      logic [7:0] reset_addrs [7];
      reset_addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'hF0};

      apb_if.PSEL    = 1'b0;
      apb_if.PENABLE = 1'b0;
      apb_if.PWRITE  = 1'b0;
      apb_if.PADDR   = '0;
      apb_if.PWDATA  = '0;
      PRESET         = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      PRESET = 1'b0;

      // Reset state
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_irq_any", {31'd0, irq_any}, 32'h0);
      chk("rst_slverr", {31'd0, apb_if.PSLVERR}, 32'h0);
      chk("rst_prdata", apb_if.PRDATA, 32'h0);
      for (int i = 0; i < 7; i++) rd_expect("rst_reg", reset_addrs[i], 32'h0, 1'b0);

      // Periodic channel 0: LOAD=4, EN|IRQEN
      wr(8'h00, 32'd4);
      wr(8'h08, 32'h5);
      t0 = cyc;
      for (int n = 0; n < 4; n++) rd_expect("per_value", 8'h04, (cyc + 1 - t0) % 5, 1'b0);
      chk("per_irq", 32'(irq), 32'h1);
      chk("per_irq_any", {31'd0, irq_any}, 32'h1);

      // W1C one edge after a terminal, then watch irq re-assert at the next one
      align(t0, 5, 3);
      wr(8'hF0, 32'h1);
      chk("w1c_irq", 32'(irq), 32'h0);
      rd_expect("w1c_status", 8'hF0, 32'h0, 1'b0);
      align(t0, 5, 4);
      chk("irq_pre_term", 32'(irq), 32'h0);
      @(posedge PCLK); #1;
      chk("irq_reassert", 32'(irq), 32'h1);

      // W1C landing on a terminal edge: set wins
      align(t0, 5, 2);
      wr(8'hF0, 32'h1);
      chk("w1c_collide_irq", 32'(irq), 32'h1);
      rd_expect("w1c_collide_status", 8'hF0, 32'h1, 1'b0);

      // LOAD write landing on a terminal edge: no status set
      align(t0, 5, 3);
      wr(8'hF0, 32'h1);
      align(t0, 5, 2);
      wr(8'h00, 32'd4);
      t0 = cyc;
      rd_expect("load_collide_status", 8'hF0, 32'h0, 1'b0);
      chk("load_collide_irq", 32'(irq), 32'h0);
      rd_expect("load_collide_value", 8'h04, (cyc + 1 - t0) % 5, 1'b0);
      wr(8'h08, 32'h0);
      wr(8'hF0, 32'h3);

      // One-shot channel 1: LOAD=2, EN|ONESHOT
      wr(8'h10, 32'd2);
      wr(8'h18, 32'h3);
      repeat (8) @(posedge PCLK);
      #1;
      chk("os_irq_masked", 32'(irq), 32'h0);
      rd_expect("os_status", 8'hF0, 32'h2, 1'b0);
      rd_expect("os_ctrl", 8'h18, 32'h2, 1'b0);
      rd_expect("os_value", 8'h14, 32'h0, 1'b0);
      wr(8'hF0, 32'h2);
      repeat (8) @(posedge PCLK);
      #1;
      rd_expect("os_once", 8'hF0, 32'h0, 1'b0);

      // CTRL write on the one-shot terminal edge keeps EN set
      wr(8'h18, 32'h3);
      t1 = cyc;
      wr(8'h18, 32'h7);
      t2 = cyc;
      chk("ctrl_wins_timing", t2 - t1, 32'd3);
      rd_expect("ctrl_wins", 8'h18, 32'h7, 1'b0);
      repeat (4) @(posedge PCLK);
      #1;
      rd_expect("ctrl_after_os", 8'h18, 32'h6, 1'b0);
      chk("os_irq", 32'(irq), 32'h2);
      chk("os_irq_any", {31'd0, irq_any}, 32'h1);
      wr(8'h18, 32'h2);
      chk("irqen_mask", 32'(irq), 32'h0);
      chk("irqen_mask_any", {31'd0, irq_any}, 32'h0);
      rd_expect("irqen_mask_status", 8'hF0, 32'h2, 1'b0);

      // Width truncation and address map
      wr(8'h00, 32'h1FF);
      rd_expect("load_width", 8'h00, 32'hFF, 1'b0);
      wr(8'h08, 32'hFFFF_FFFE);
      rd_expect("ctrl_bits", 8'h08, 32'h6, 1'b0);
      wr(8'h08, 32'h0);
      rd_expect("unmapped_rd", 8'h20, 32'h0, 1'b1);
      apb_write(8'h20, 32'h55, werr);
      chk("unmapped_wr_err", {31'd0, werr}, 32'h1);
      apb_write(8'h28, 32'h7, werr);
      chk("unmapped_wr_err2", {31'd0, werr}, 32'h1);
      rd_expect("unmapped_no_load", 8'h00, 32'hFF, 1'b0);
      rd_expect("unmapped_no_ctrl", 8'h08, 32'h0, 1'b0);
      rd_expect("unmapped_no_load1", 8'h10, 32'h2, 1'b0);
      rd_expect("status_no_err", 8'hF0, 32'h2, 1'b0);
      rd_expect("reserved_f4", 8'hF4, 32'h0, 1'b0);
      rd_expect("reserved_off3", 8'h0C, 32'h0, 1'b0);
      rd_expect("unmapped_rd30", 8'h30, 32'h0, 1'b1);

      // Reset mid-count
      wr(8'h00, 32'd10);
      wr(8'h08, 32'h5);
      t0 = cyc;
      align(t0, 11, 2);
      rd_expect("midrst_value", 8'h04, (cyc + 1 - t0) % 11, 1'b0);
      rd_expect("midrst_status_pre", 8'hF0, 32'h2, 1'b0);
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      chk("midrst_irq", 32'(irq), 32'h0);
      chk("midrst_irq_any", {31'd0, irq_any}, 32'h0);
      rd_expect("midrst_value0", 8'h04, 32'h0, 1'b0);
      rd_expect("midrst_ctrl", 8'h08, 32'h0, 1'b0);
      rd_expect("midrst_status", 8'hF0, 32'h0, 1'b0);
      rd_expect("midrst_load", 8'h00, 32'h0, 1'b0);
      rd_expect("midrst_load1", 8'h10, 32'h0, 1'b0);
      rd_expect("midrst_value_idle", 8'h04, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_multi_timer.md
Name: apb_multi_timer

Overview:
- Parametrised successor to the single-channel APB delay timer: NCH independent up-counting timers of WIDTH bits behind one APB slave.
- Adds per-channel one-shot/periodic mode, sticky terminal-count status with write-1-to-clear, per-channel interrupt enables and an error response on unmapped addresses.
- Sits on the APB peripheral bus; irq outputs go to the interrupt controller.

Parameters:
NCH, 4, number of timer channels (1..15)
WIDTH, 32, counter/load width in bits (8..32)

Ports:
PCLK  in  1  bus and timer clock
PRESET  in  1  synchronous active-high reset
PSEL  in  1  APB slave select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  8  byte address; [1:0] ignored
PWDATA  in  32  write data
PRDATA  out  32  read data, registered
PREADY  out  1  tied 1 (no wait states)
PSLVERR  out  1  error on unmapped access
irq  out  NCH  per-channel interrupt, status[i] & IRQEN[i]
irq_any  out  1  OR of irq

Behaviour:
- Reset (PRESET=1 at PCLK edge): all LOAD, CTRL, counters and status = 0; PRDATA = 0; PSLVERR = 0; irq = 0. Reset mid-count discards all state.
- Address map: channel c = PADDR[7:4] (c < NCH); offset PADDR[3:2]: 0 LOAD (RW), 1 VALUE (RO), 2 CTRL (RW), 3 reserved (reads 0, writes ignored). 0xF0 STATUS (bit i per channel; read; write-1-to-clear). 0xF4..0xFC reserved.
- CTRL bits: [0] EN, [1] ONESHOT, [2] IRQEN; other bits read 0.
- Write strobe = PSEL & PENABLE & PWRITE; registers update at that edge.
- Read: PRDATA is loaded at the setup-phase edge (PSEL & !PENABLE & !PWRITE), so it is valid throughout the access phase. PRDATA holds its value otherwise.
- Width: LOAD/VALUE use PWDATA[WIDTH-1:0]; upper bits are ignored on write and read as 0.
- PSLVERR = 1 only during the access phase (PSEL & PENABLE) when PADDR[7:4] >= NCH and PADDR[7:4] != 0xF; otherwise 0. Erroring writes change no state; erroring reads return 0.
- Counter per channel, priority highest first:
  1. LOAD write to this channel -> counter = 0 next cycle; no terminal event that cycle.
  2. EN=0 -> counter = 0.
  3. EN=1 and counter == LOAD (terminal) -> counter = 0 and status[i] set. If ONESHOT=1, EN is also cleared by hardware in the same cycle.
  4. EN=1 -> counter + 1.
- Period: LOAD+1 cycles. LOAD=0 with EN=1 is terminal every cycle (periodic) or after 1 cycle (one-shot). Counter never exceeds LOAD, so no 2^WIDTH wrap in normal use.
- A CTRL write in the same cycle as a hardware EN-clear: the CTRL write wins.
- STATUS W1C in the same cycle as a hardware set of the same bit: the set wins (bit stays 1). Writing 0s has no effect.
- irq[i] is combinational from the registered status and IRQEN, so it asserts the cycle after the terminal edge. Clearing IRQEN masks irq but does not clear status.

Test Plan:
- Reset: PRESET high for 2 cycles -> every readable register returns 0; irq=0; PSLVERR=0.
- Periodic: ch0 LOAD=4, CTRL=0x5 -> VALUE sequence 0,1,2,3,4,0...; status[0] sets every 5 cycles; irq[0]=1 until W1C 0x1 to 0xF0, then re-asserts at the next terminal.
- One-shot: ch1 LOAD=2, CTRL=0x3 -> status[1] sets once at the terminal; CTRL reads 0x2 (EN cleared); VALUE stays 0.
- Collisions: W1C on 0xF0 in the same cycle as a ch0 terminal -> status[0] remains 1. LOAD write in the terminal cycle -> VALUE=0, no status set.
- Width/map: WIDTH=8, NCH=2; write LOAD=0x1FF -> reads 0xFF. Read at 0x20 -> PSLVERR=1, PRDATA=0. Write at 0x20 -> no state change. Read at 0xF0 -> PSLVERR=0.
- Reset mid-count: ch0 running with VALUE=3; assert PRESET 1 cycle -> VALUE=0, CTRL=0, status=0, irq=0.
